// File: rtl/div_sched.sv
// Shares one unsigned divider core across div.w/mod.w/div.wu/mod.wu, with sign fix-up and flush drain.
// Optional: define DIV_ZERO_BYPASS_EN to answer divide-by-zero locally without using the core.
module div_sched #(
  parameter int unsigned DIV_LAT_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_mod,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [31:0] dvd_tdata,
  output logic        dvd_tvalid,
  input  logic        dvd_tready,
  output logic [31:0] dvs_tdata,
  output logic        dvs_tvalid,
  input  logic        dvs_tready,
  input  logic [63:0] dout_tdata,
  input  logic        dout_tvalid,
  output logic        err_timeout
);

  localparam int unsigned WD_W = $clog2(DIV_LAT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic              mod_q, mod_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [31:0]       dvd_q, dvd_d;
  logic [31:0]       dvs_q, dvs_d;
  logic              dvd_sent_q, dvd_sent_d;
  logic              dvs_sent_q, dvs_sent_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic        accept;
  logic        dvd_done, dvs_done;
  logic [31:0] q_fix, r_fix;

  assign req_ready   = (state_q == S_IDLE) && !flush && !reset;
  assign accept      = req_valid && req_ready;
  assign dvd_tvalid  = (state_q == S_SEND) && !dvd_sent_q;
  assign dvs_tvalid  = (state_q == S_SEND) && !dvs_sent_q;
  assign dvd_tdata   = dvd_q;
  assign dvs_tdata   = dvs_q;
  assign resp_valid  = (state_q == S_DONE);
  assign resp_result = result_q;
  assign err_timeout = err_q;

  assign dvd_done = dvd_sent_q || (dvd_tvalid && dvd_tready);
  assign dvs_done = dvs_sent_q || (dvs_tvalid && dvs_tready);
  assign q_fix    = negq_q ? -dout_tdata[63:32] : dout_tdata[63:32];
  assign r_fix    = negr_q ? -dout_tdata[31:0]  : dout_tdata[31:0];

  always_comb begin
    state_d      = state_q;
    mod_d        = mod_q;
    negq_d       = negq_q;
    negr_d       = negr_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    dvd_sent_d   = dvd_sent_q;
    dvs_sent_d   = dvs_sent_q;
    flush_pend_d = flush_pend_q;
    result_d     = result_q;
    err_d        = err_q;
    wd_d         = wd_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mod_d        = req_mod;
          negq_d       = req_signed && (req_src1[31] ^ req_src2[31]);
          negr_d       = req_signed && req_src1[31];
          dvd_d        = (req_signed && req_src1[31]) ? -req_src1 : req_src1;
          dvs_d        = (req_signed && req_src2[31]) ? -req_src2 : req_src2;
          dvd_sent_d   = 1'b0;
          dvs_sent_d   = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = S_SEND;
`ifdef DIV_ZERO_BYPASS_EN
          if (req_src2 == '0) begin
            result_d = req_mod ? req_src1 : '1;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_SEND: begin
        // AXI forbids withdrawing tvalid, so a flush here is remembered until both channels go out
        dvd_sent_d   = dvd_done;
        dvs_sent_d   = dvs_done;
        flush_pend_d = flush_pend_q || flush;
        if (dvd_done && dvs_done) begin
          state_d = (flush_pend_q || flush) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = dout_tvalid ? S_IDLE : S_DRAIN;
        end else if (dout_tvalid) begin
          result_d = mod_q ? r_fix : q_fix;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready || flush) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dout_tvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d inside {S_WAIT, S_DRAIN}) && (state_d != state_q)) begin
      wd_d = '0;
    end else if ((state_q inside {S_WAIT, S_DRAIN}) && (wd_q != WD_W'(DIV_LAT_MAX))) begin
      wd_d = wd_q + 1'b1;
    end
    if ((state_q inside {S_WAIT, S_DRAIN}) && (wd_q == WD_W'(DIV_LAT_MAX))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mod_q        <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      dvd_sent_q   <= 1'b0;
      dvs_sent_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      mod_q        <= mod_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      dvd_sent_q   <= dvd_sent_d;
      dvs_sent_q   <= dvs_sent_d;
      flush_pend_q <= flush_pend_d;
      result_q     <= result_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: behavioural divider core, arithmetic reference model and per-cycle result check.
module tb_div_sched;

  logic        clk;
  logic        reset, flush;
  logic        req_valid, req_ready, req_signed, req_mod;
  logic [31:0] req_src1, req_src2;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic [31:0] dvd_tdata, dvs_tdata;
  logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready;
  logic [63:0] dout_tdata;
  logic        dout_tvalid;
  logic        err_timeout;

  div_sched #(.DIV_LAT_MAX(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_mod(req_mod),
    .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .dvd_tdata(dvd_tdata), .dvd_tvalid(dvd_tvalid), .dvd_tready(dvd_tready),
    .dvs_tdata(dvs_tdata), .dvs_tvalid(dvs_tvalid), .dvs_tready(dvs_tready),
    .dout_tdata(dout_tdata), .dout_tvalid(dout_tvalid), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int core_lat = 1;
  int dvs_stall = 0;
  int core_ops = 0;
  int dvd_hi = 0;
  int dvs_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division semantics, truncating toward zero
  function automatic logic [31:0] model(input logic s, input logic m,
                                        input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'h0) return m ? a : 32'hFFFFFFFF;
    if (!s) return m ? (a % b) : (a / b);
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return m ? 32'h0 : 32'h80000000;
    sa = a;
    sb = b;
    return m ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Behavioural divider core: independent channel handshakes, fixed latency, one-cycle result
  initial begin
    logic [31:0] a, b, qq, rr;
    logic got_a, got_b;
    int cd;
    dvd_tready = 1'b0; dvs_tready = 1'b0; dout_tvalid = 1'b0; dout_tdata = '0;
    got_a = 1'b0; got_b = 1'b0; cd = 0; a = '0; b = '0; qq = '0; rr = '0;
    forever begin
      @(negedge clk);
      dout_tvalid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dout_tvalid = 1'b1;
          dout_tdata  = {qq, rr};
        end
      end
      dvd_tready = 1'b1;
      dvs_tready = (dvs_stall == 0);
      #1;
      if (dvd_tvalid) dvd_hi++;
      if (dvs_tvalid) dvs_hi++;
      if (dvs_tvalid && !dvs_tready) dvs_stall--;
      if (dvd_tvalid && dvd_tready) begin a = dvd_tdata; got_a = 1'b1; end
      if (dvs_tvalid && dvs_tready) begin b = dvs_tdata; got_b = 1'b1; end
      if (got_a && got_b) begin
        got_a = 1'b0; got_b = 1'b0;
        core_ops++;
        qq = (b == 0) ? 32'hFFFFFFFF : a / b;
        rr = (b == 0) ? a : a % b;
        cd = core_lat;
      end
    end
  end

  // Result checker: every cycle resp_valid is high the result must match the oldest expected value
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp_valid", 32'(resp_valid), 32'h0);
        end else begin
          chk("resp_result", resp_result, exp_q[0]);
          if (resp_ready || flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic s, input logic m, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_signed = s; req_mod = m; req_src1 = a; req_src2 = b;
    n = 0;
    #1;
    while (!req_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) chk("req_accept_timeout", 32'(req_ready), 32'h1);
    if (push) exp_q.push_back(model(s, m, a, b));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk); #3; n++;
    end
    chk("drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    @(negedge clk); #3;
    while (!resp_valid && n < 200) begin
      @(negedge clk); #3; n++;
    end
    chk("resp_valid_seen", 32'(resp_valid), 32'h1);
  endtask

  typedef struct { logic s; logic m; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t vt[10];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_mod = 1'b0;
    req_src1 = '0; req_src2 = '0; resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("req_ready_in_reset", 32'(req_ready), 32'h0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_dvd_tvalid", 32'(dvd_tvalid), 32'h0);
    chk("rst_dvs_tvalid", 32'(dvs_tvalid), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);
    chk("rst_resp_result", resp_result, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    chk("model_sdiv_7_m2", model(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE), 32'hFFFFFFFD);
    chk("model_smod_7_m2", model(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE), 32'h00000001);
    chk("model_smod_m7_2", model(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    chk("model_udiv", model(1'b0, 1'b0, 32'hFFFFFFFF, 32'h10), 32'h0FFFFFFF);
    chk("model_ovf_div", model(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("model_ovf_mod", model(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF), 32'h00000000);
    chk("model_udiv_100_7", model(1'b0, 1'b0, 32'd100, 32'd7), 32'd14);
    chk("model_sdiv_m100_m7", model(1'b1, 1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9), 32'd14);

    vt[0] = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFE};
    vt[1] = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE};
    vt[2] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2};
    vt[3] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h10};
    vt[4] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF};
    vt[5] = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF};
    vt[6] = '{1'b1, 1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9};
    vt[7] = '{1'b1, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9};
    vt[8] = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7};
    vt[9] = '{1'b0, 1'b0, 32'd3,        32'd10};
    for (int i = 0; i < 10; i++) begin
      core_lat = 1 + (i % 4);
      issue(vt[i].s, vt[i].m, vt[i].a, vt[i].b, 1'b1);
    end
    drain();

    // Divisor channel stalled 5 cycles
    core_lat = 2; dvd_hi = 0; dvs_hi = 0; core_ops = 0; dvs_stall = 5;
    issue(1'b0, 1'b0, 32'd1000, 32'd10, 1'b1);
    drain();
    chk("stall_dvd_hi_cycles", 32'(dvd_hi), 32'd1);
    chk("stall_dvs_hi_cycles", 32'(dvs_hi), 32'd6);
    chk("stall_core_ops", 32'(core_ops), 32'd1);

    // Flush while waiting for the core
    core_lat = 4; core_ops = 0;
    issue(1'b0, 1'b0, 32'd55, 32'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("drain_blocks_req", 32'(req_ready), 32'h0);
    core_lat = 2;
    issue(1'b0, 1'b0, 32'd100, 32'd7, 1'b1);
    drain();
    chk("flush_wait_core_ops", 32'(core_ops), 32'd2);

    // Flush during SEND with divisor stalled: channel must still complete
    core_lat = 3; core_ops = 0; dvd_hi = 0; dvs_hi = 0; dvs_stall = 3;
    issue(1'b1, 1'b0, 32'hFFFFFFCE, 32'd3, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("flush_send_dvs_hi", 32'(dvs_hi), 32'd4);
    chk("flush_send_dvd_hi", 32'(dvd_hi), 32'd1);
    chk("flush_send_core_ops", 32'(core_ops), 32'd1);
    chk("flush_send_idle", 32'(req_ready), 32'h1);
    issue(1'b1, 1'b1, 32'hFFFFFFCE, 32'd3, 1'b1);
    drain();

    // dout_tvalid and flush in the same WAIT cycle: straight back to IDLE
    core_lat = 3;
    issue(1'b0, 1'b0, 32'd9, 32'd3, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (dout_tvalid) break;
    end
    chk("dout_seen", 32'(dout_tvalid), 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_dout_same_cycle_idle", 32'(req_ready), 32'h1);

    // Consumer back-pressure for 4 cycles
    core_lat = 2; resp_ready = 1'b0;
    issue(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_resp();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("bp_req_ready_low", 32'(req_ready), 32'h0);
      chk("bp_resp_valid_held", 32'(resp_valid), 32'h1);
    end
    resp_ready = 1'b1;
    drain();

    // Flush in DONE consumes the result
    resp_ready = 1'b0;
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
    wait_resp();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_done_resp_cleared", 32'(resp_valid), 32'h0);
    chk("flush_done_idle", 32'(req_ready), 32'h1);
    resp_ready = 1'b1;

`ifdef DIV_ZERO_BYPASS_EN
    dvd_hi = 0; dvs_hi = 0; core_ops = 0;
    issue(1'b0, 1'b0, 32'h1234, 32'h0, 1'b1);
    issue(1'b1, 1'b1, 32'h1234, 32'h0, 1'b1);
    drain();
    chk("bypass_dvd_never_valid", 32'(dvd_hi), 32'h0);
    chk("bypass_dvs_never_valid", 32'(dvs_hi), 32'h0);
    chk("bypass_core_ops", 32'(core_ops), 32'h0);
`endif

    // Watchdog: a slow core trips the sticky flag but the result still arrives
    chk("wd_err_clear_before", 32'(err_timeout), 32'h0);
    core_lat = 100;
    issue(1'b0, 1'b0, 32'd5, 32'd1, 1'b1);
    repeat (40) @(negedge clk);
    #1;
    chk("wd_err_clear_at_40", 32'(err_timeout), 32'h0);
    drain();
    chk("wd_err_set", 32'(err_timeout), 32'h1);
    core_lat = 1;
    issue(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 1'b1);
    drain();
    chk("wd_err_sticky", 32'(err_timeout), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
